// File: rtl/pcm_pwm_player.sv
// PCM playback: fetches one FIFO sample per sample period and renders it as
// a 2^dat_width-clock PWM stream for the audio amplifier.
module pcm_pwm_player #(
    parameter int dat_width  = 6,
    parameter int sample_div = 1042
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [dat_width-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 pwm_out,
    output logic                 audio_sd,
    output logic                 underrun
);

    typedef enum logic [1:0] {IDLE, RUN, FETCH} state_t;

    localparam logic [15:0]          DIV_LAST = 16'(sample_div - 1);
    localparam logic [dat_width-1:0] MIDSCALE = {1'b1, {(dat_width-1){1'b0}}};

    state_t               state;
    logic [15:0]          div_cnt;
    logic [dat_width-1:0] pwm_cnt;
    logic [dat_width-1:0] held;
    logic [dat_width-1:0] active;
    logic [dat_width-1:0] active_next;
    logic                 rd_q;
    logic                 tick;

    assign tick = (div_cnt == DIV_LAST);

    // New sample takes effect only at the start of a PWM period.
    always_comb begin
        active_next = active;
        if (pwm_cnt == '0) begin
            active_next = held;
        end
    end

    // Reset gates the strobe so a FETCH interrupted by reset does not pop the FIFO.
    assign fifo_rd = rd_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_q     <= 1'b0;
            pwm_out  <= 1'b0;
            audio_sd <= 1'b0;
            underrun <= 1'b0;
            div_cnt  <= '0;
            pwm_cnt  <= '0;
            held     <= MIDSCALE;
            active   <= MIDSCALE;
        end else if (!en) begin
            // The read strobe was already presented this cycle, so keep its data.
            if (state == FETCH) begin
                held <= fifo_data;
            end
            state    <= IDLE;
            rd_q     <= 1'b0;
            pwm_out  <= 1'b0;
            audio_sd <= 1'b0;
            div_cnt  <= '0;
            pwm_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= RUN;
                    audio_sd <= 1'b1;
                    pwm_out  <= 1'b0;
                    rd_q     <= 1'b0;
                end
                RUN, FETCH: begin
                    div_cnt <= tick ? '0 : div_cnt + 16'd1;
                    pwm_cnt <= pwm_cnt + dat_width'(1);
                    active  <= active_next;
                    pwm_out <= (pwm_cnt < active_next);
                    rd_q    <= 1'b0;
                    state   <= RUN;
                    if (state == FETCH) begin
                        held <= fifo_data;
                    end else if (tick) begin
                        if (!fifo_empty) begin
                            state <= FETCH;
                            rd_q  <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_pwm_player.sv
// Bench for pcm_pwm_player: FIFO model, per-period duty / read-time / underrun
// reference model feeding a scoreboard, checked by an independent monitor.
module tb_pcm_pwm_player;

    localparam int D0 = 1042;
    localparam int P0 = 64;
    localparam int D1 = 16;
    localparam int P1 = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] en = '0;
    logic [1:0] fifo_empty, fifo_rd, pwm_out, audio_sd, underrun;

    logic [5:0] mem0 [64];
    logic [3:0] mem1 [64];
    logic [6:0] wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
    logic [5:0] fifo_data0;
    logic [3:0] fifo_data1;

    int n_chk = 0;
    int n_fail = 0;

    int exp_rd[$];
    int exp_und[$];
    int exp_duty[$];
    int av_v[$];
    int av_w[$];
    int model_held[2] = '{32, 8};
    bit und_flag[2] = '{1'b0, 1'b0};

    int   rel[2] = '{-1, -1};
    int   hi[2] = '{0, 0};
    logic prev_rd[2] = '{1'b0, 1'b0};
    logic prev_und[2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    assign fifo_empty[0] = (wp0 == rp0);
    assign fifo_empty[1] = (wp1 == rp1);
    assign fifo_data0    = mem0[rp0[5:0]];
    assign fifo_data1    = mem1[rp1[5:0]];

    always @(posedge clk) begin
        if (fifo_rd[0] && !fifo_empty[0]) rp0 <= rp0 + 7'd1;
        if (fifo_rd[1] && !fifo_empty[1]) rp1 <= rp1 + 7'd1;
    end

    pcm_pwm_player #(.dat_width(6), .sample_div(D0)) dut0 (
        .clk(clk), .reset(reset), .en(en[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data0), .fifo_rd(fifo_rd[0]), .pwm_out(pwm_out[0]),
        .audio_sd(audio_sd[0]), .underrun(underrun[0])
    );

    pcm_pwm_player #(.dat_width(4), .sample_div(D1)) dut1 (
        .clk(clk), .reset(reset), .en(en[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data1), .fifo_rd(fifo_rd[1]), .pwm_out(pwm_out[1]),
        .audio_sd(audio_sd[1]), .underrun(underrun[1])
    );

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void report_extra(string name, int act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event, got %0d, expected none", name, act);
    endfunction

    task automatic fifo_push(input int d, input int v);
        if (d == 0) begin
            mem0[wp0[5:0]] = 6'(v);
            wp0 = wp0 + 7'd1;
        end else begin
            mem1[wp1[5:0]] = 4'(v);
            wp1 = wp1 + 7'd1;
        end
    endtask

    task automatic preload(input int d, input int v);
        fifo_push(d, v);
        av_v.push_back(v);
        av_w.push_back(0);
    endtask

    // Cycle numbers are counted from the enable edge (audio_sd first high = 0).
    // A sample visible by a tick cycle t is read in cycle t+1; PWM period p
    // plays whatever sample was held at cycle p*period.
    task automatic plan(input int d, input int r);
        int dv = (d == 0) ? D0 : D1;
        int per = (d == 0) ? P0 : P1;
        int f_cyc[$];
        int f_val[$];
        int h;
        for (int t = dv - 1; t < r; t += dv) begin
            if (av_w.size() > 0 && av_w[0] <= t) begin
                f_cyc.push_back(t + 1);
                f_val.push_back(av_v.pop_front());
                void'(av_w.pop_front());
                exp_rd.push_back(t + 1);
            end else if (!und_flag[d]) begin
                und_flag[d] = 1'b1;
                exp_und.push_back(t + 1);
            end
        end
        for (int p = 0; p < r / per; p++) begin
            h = model_held[d];
            foreach (f_cyc[i]) if (f_cyc[i] + 1 <= p * per) h = f_val[i];
            exp_duty.push_back(h);
        end
        if (f_val.size() > 0) model_held[d] = f_val[f_val.size() - 1];
    endtask

    task automatic run(input int d, input int r, input int late_w, input int late_v);
        if (late_w >= 0) begin
            av_v.push_back(late_v);
            av_w.push_back(late_w);
        end
        plan(d, r);
        @(posedge clk);
        #1 en[d] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= r; k++) begin
            @(posedge clk);
            if (k == late_w) #1 fifo_push(d, late_v);
        end
        #1 en[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("off_pwm", int'(pwm_out[d]), 0);
        check("off_sd", int'(audio_sd[d]), 0);
        check("off_rd", int'(fifo_rd[d]), 0);
        repeat (2) @(negedge clk);
        check("rd_left", exp_rd.size(), 0);
        check("und_left", exp_und.size(), 0);
        check("duty_left", exp_duty.size(), 0);
        check("underrun_lvl", int'(underrun[d]), int'(und_flag[d]));
    endtask

    task automatic reset_checks();
        for (int d = 0; d < 2; d++) begin
            check("rst_rd", int'(fifo_rd[d]), 0);
            check("rst_pwm", int'(pwm_out[d]), 0);
            check("rst_sd", int'(audio_sd[d]), 0);
            check("rst_und", int'(underrun[d]), 0);
            und_flag[d] = 1'b0;
        end
        model_held[0] = 32;
        model_held[1] = 8;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_checks();
    endtask

    // Monitor: reacts only to DUT outputs and pops the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rel[d] = audio_sd[d] ? rel[d] + 1 : -1;
                if (fifo_rd[d]) begin
                    check("rd_guard", int'(fifo_empty[d] | prev_rd[d]), 0);
                    if (exp_rd.size() == 0) report_extra("rd_cycle", rel[d]);
                    else check("rd_cycle", rel[d], exp_rd.pop_front());
                end
                if (underrun[d] && !prev_und[d]) begin
                    if (exp_und.size() == 0) report_extra("und_cycle", rel[d]);
                    else check("und_cycle", rel[d], exp_und.pop_front());
                end
                if (audio_sd[d] && rel[d] >= 1) begin
                    hi[d] += int'(pwm_out[d]);
                    if (rel[d] % ((d == 0) ? P0 : P1) == 0) begin
                        if (exp_duty.size() == 0) report_extra("duty", hi[d]);
                        else check("duty", hi[d], exp_duty.pop_front());
                        hi[d] = 0;
                    end
                end else if (!audio_sd[d]) begin
                    hi[d] = 0;
                end
                prev_rd[d]  = fifo_rd[d];
                prev_und[d] = underrun[d];
            end
        end
    end

    initial begin
        int v;
        int w;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_checks();

        // Empty FIFO: midscale output, underrun at the first tick, no reads.
        run(0, 3 * D0 + 10, -1, 0);

        // Preloaded 0, 63, 16 then underrun at the fourth tick.
        do_reset();
        preload(0, 0);
        preload(0, 63);
        preload(0, 16);
        run(0, 4 * D0 + 10, -1, 0);

        // Sample written around a tick is consumed exactly once.
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 40 : int'($urandom_range(0, 63));
            w = D0 - 2 + int'($urandom_range(0, 2));
            run(0, 2 * D0 + 100, w, v);
        end

        // Disable mid-period at 50, then resume with the held sample.
        preload(0, 50);
        run(0, D0 + 200, -1, 0);
        run(0, 500, -1, 0);

        // Reset during FETCH: no read, sample stays in the FIFO.
        do_reset();
        preload(0, 7);
        plan(0, D0 - 1);
        @(posedge clk);
        #1 en[0] = 1'b1;
        @(posedge clk);
        repeat (D0) @(posedge clk);
        #1 begin
            reset = 1'b1;
            en[0] = 1'b0;
        end
        @(negedge clk);
        check("rd_at_reset", int'(fifo_rd[0]), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_checks();
        check("fifo_level", int'(7'(wp0 - rp0)), av_v.size());
        check("duty_left", exp_duty.size(), 0);
        run(0, D0 + 300, -1, 0);

        // Narrow instance: back-to-back reads every 16 clocks, 16-clock PWM.
        for (int i = 0; i < 6; i++) preload(1, int'($urandom_range(0, 15)));
        run(1, 7 * D1 + 5, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
